linebuf_ctrl: RTL and testbench

Single-clock sequencer that drives the 4-line video line buffer from a raw pixel stream (VS/HS/DE + data). Generates the line buffer write address/enable, read address/enable, and a 3-row window-valid flag. Also generates sync/DE outputs delayed to line up with the buffer's RD0..RD2 outputs. Sits between the camera/video input stage and the 3x3 filter datapath.

---
 rtl/linebuf_ctrl_if.sv | 33 +++
 rtl/linebuf_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_linebuf_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/linebuf_ctrl_if.sv
// linebuf_ctrl_if -- pixel-stream input and line-buffer port bundle for linebuf_ctrl.
// slave: the sequencer side. master: the side that drives the stream and observes the buffer ports.
interface linebuf_ctrl_if #(
    parameter int DataWidth  = 24,
    parameter int XADRSWidth = 11,
    parameter int YADRSWidth = 10
);
    logic                             VS_IN;
    logic                             HS_IN;
    logic                             DE_IN;
    logic [DataWidth-1:0]             D_IN;
    logic [XADRSWidth+YADRSWidth-1:0] WA;
    logic                             WEN;
    logic [DataWidth-1:0]             WD;
    logic [XADRSWidth+YADRSWidth-1:0] RA;
    logic                             REN;
    logic                             VS_OUT;
    logic                             HS_OUT;
    logic                             DE_OUT;
    logic                             WIN_VALID;
    logic [YADRSWidth-1:0]            LINE_CNT;
    logic                             ERR;

    modport slave (
        input  VS_IN, HS_IN, DE_IN, D_IN,
        output WA, WEN, WD, RA, REN, VS_OUT, HS_OUT, DE_OUT, WIN_VALID, LINE_CNT, ERR
    );

    modport master (
        output VS_IN, HS_IN, DE_IN, D_IN,
        input  WA, WEN, WD, RA, REN, VS_OUT, HS_OUT, DE_OUT, WIN_VALID, LINE_CNT, ERR
    );
endinterface

// File: rtl/linebuf_ctrl.sv
// linebuf_ctrl -- write/read sequencer for a 4-line video line buffer.
// Tracks column/line position of the incoming pixel stream, drives the buffer
// write and read ports one cycle after each DE pixel, and delays VS/HS/DE plus a
// 3-row window-valid flag so they line up with the buffer read data.
// Optional frame-format checking is built when LINEBUF_CTRL_ERRCHK_EN is defined.
module linebuf_ctrl #(
    parameter int DataWidth  = 24,
    parameter int XADRSWidth = 11,
    parameter int YADRSWidth = 10,
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720,
    parameter int RD_LATENCY = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    linebuf_ctrl_if.slave bus
);
    localparam int DLY_DEPTH = 1 + RD_LATENCY;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                           state_r;
    state_t                           state_n;
    logic                             vs_prev_r;
    logic                             de_prev_r;
    logic [XADRSWidth-1:0]            x_r;
    logic [XADRSWidth-1:0]            x_cur_s;
    logic [XADRSWidth-1:0]            x_n;
    logic [YADRSWidth-1:0]            y_r;
    logic [YADRSWidth-1:0]            y_cur_s;
    logic [YADRSWidth-1:0]            y_n;
    logic                             vs_rise_s;
    logic                             de_fall_s;
    logic                             active_s;
    logic                             pix_err_s;
    logic                             wr_s;
    logic                             win_s;
    logic                             err_r;
    logic                             err_n;
    logic [XADRSWidth+YADRSWidth-1:0] wa_r;
    logic [XADRSWidth+YADRSWidth-1:0] ra_r;
    logic [DataWidth-1:0]             wd_r;
    logic                             wen_r;
    logic                             ren_r;
    logic [3:0]                       dly_r [DLY_DEPTH];

`ifdef LINEBUF_CTRL_ERRCHK_EN
    // One extra bit so a limit equal to 2^width still compares correctly.
    localparam logic [XADRSWidth:0] H_LIM = (XADRSWidth + 1)'(H_ACTIVE);
    localparam logic [YADRSWidth:0] V_LIM = (YADRSWidth + 1)'(V_ACTIVE);
    logic                           de_rise_s;
`endif

    // Edge detection, position counters, write qualification and error flag
    always_comb begin
        vs_rise_s = bus.VS_IN & ~vs_prev_r;
        de_fall_s = ~bus.DE_IN & de_prev_r;
        // VS is handled first: a coincident pixel lands on line 0, column 0.
        active_s  = (state_r != IDLE) | vs_rise_s;
        x_cur_s   = vs_rise_s ? {XADRSWidth{1'b0}} : x_r;
        y_cur_s   = vs_rise_s ? {YADRSWidth{1'b0}} : y_r;

        if (!active_s) begin
            x_n = x_r;
            y_n = y_r;
        end else begin
            if (bus.DE_IN) begin
                x_n = x_cur_s + XADRSWidth'(1);
            end else if (de_fall_s) begin
                x_n = {XADRSWidth{1'b0}};
            end else begin
                x_n = x_cur_s;
            end
            if (de_fall_s && !vs_rise_s && (y_r != {YADRSWidth{1'b1}})) begin
                y_n = y_r + YADRSWidth'(1);
            end else begin
                y_n = y_cur_s;
            end
        end

`ifdef LINEBUF_CTRL_ERRCHK_EN
        de_rise_s = bus.DE_IN & ~de_prev_r;
        pix_err_s = active_s & bus.DE_IN &
                    (({1'b0, x_cur_s} >= H_LIM) | (de_rise_s & ({1'b0, y_cur_s} >= V_LIM)));
        err_n     = (err_r & ~vs_rise_s) | pix_err_s;
`else
        pix_err_s = 1'b0;
        err_n     = 1'b0;
`endif

        wr_s  = active_s & bus.DE_IN & ~pix_err_s;
        win_s = bus.DE_IN & (state_r == RUN) & ~vs_rise_s;
    end

    // Frame sequencing: IDLE until first VS, FILL until three lines stored, then RUN
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (vs_rise_s) begin
                    state_n = FILL;
                end else begin
                    state_n = IDLE;
                end
            end
            FILL: begin
                if (vs_rise_s) begin
                    state_n = FILL;
                end else if (y_n >= YADRSWidth'(3)) begin
                    state_n = RUN;
                end else begin
                    state_n = FILL;
                end
            end
            RUN: begin
                if (vs_rise_s) begin
                    state_n = FILL;
                end else begin
                    state_n = RUN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Counters, edge history, error flag and registered buffer port outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            x_r       <= {XADRSWidth{1'b0}};
            y_r       <= {YADRSWidth{1'b0}};
            vs_prev_r <= 1'b0;
            de_prev_r <= 1'b0;
            err_r     <= 1'b0;
            wen_r     <= 1'b0;
            ren_r     <= 1'b0;
            wa_r      <= {(XADRSWidth + YADRSWidth){1'b0}};
            ra_r      <= {(XADRSWidth + YADRSWidth){1'b0}};
            wd_r      <= {DataWidth{1'b0}};
        end else begin
            x_r       <= x_n;
            y_r       <= y_n;
            vs_prev_r <= bus.VS_IN;
            de_prev_r <= bus.DE_IN;
            err_r     <= err_n;
            wen_r     <= wr_s;
            ren_r     <= wr_s;
            if (wr_s) begin
                wa_r <= {y_cur_s, x_cur_s};
                ra_r <= {{YADRSWidth{1'b0}}, x_cur_s};
                wd_r <= bus.D_IN;
            end
        end
    end

    // Sync/DE/window delay line matching the buffer read latency
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DLY_DEPTH; i++) begin
                dly_r[i] <= 4'b0000;
            end
        end else begin
            dly_r[0] <= {bus.VS_IN, bus.HS_IN, bus.DE_IN, win_s};
            for (int i = 1; i < DLY_DEPTH; i++) begin
                dly_r[i] <= dly_r[i-1];
            end
        end
    end

    assign bus.WA        = wa_r;
    assign bus.WEN       = wen_r;
    assign bus.WD        = wd_r;
    assign bus.RA        = ra_r;
    assign bus.REN       = ren_r;
    assign bus.VS_OUT    = dly_r[DLY_DEPTH-1][3];
    assign bus.HS_OUT    = dly_r[DLY_DEPTH-1][2];
    assign bus.DE_OUT    = dly_r[DLY_DEPTH-1][1];
    assign bus.WIN_VALID = dly_r[DLY_DEPTH-1][0];
    assign bus.LINE_CNT  = y_r;
    assign bus.ERR       = err_r;
endmodule

// File: tb/tb_linebuf_ctrl.sv
// tb_linebuf_ctrl -- self-checking bench for linebuf_ctrl.
// Write-port expectations are queued when a cycle is driven and compared one
// cycle later; sync/window expectations are compared three cycles later.
module tb_linebuf_ctrl;
    localparam int DW    = 24;
    localparam int XW    = 11;
    localparam int YW    = 10;
    localparam int AW    = XW + YW;
    localparam int H_ACT = 1280;
`ifdef LINEBUF_CTRL_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    typedef struct {
        int            due;
        logic          wen;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [YW-1:0] lc;
        logic          err;
    } wexp_t;

    typedef struct {
        int   due;
        logic vs;
        logic hs;
        logic de;
        logic win;
    } sexp_t;

    typedef struct {
        logic          vs;
        logic          hs;
        logic          de;
        logic          wen;
        logic [AW-1:0] wa;
        logic [YW-1:0] lc;
        logic          win;
    } vec_t;

    logic  CLK;
    logic  RESET;
    int    errors;
    int    checks;
    int    cyc;
    logic  err_exp;
    wexp_t wq[$];
    sexp_t sq[$];
    vec_t  tbl[13];

    linebuf_ctrl_if #(.DataWidth(DW), .XADRSWidth(XW), .YADRSWidth(YW)) bus ();

    linebuf_ctrl #(
        .DataWidth(DW), .XADRSWidth(XW), .YADRSWidth(YW),
        .H_ACTIVE(H_ACT), .V_ACTIVE(720), .RD_LATENCY(2)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_due();
        wexp_t         w;
        sexp_t         s;
        logic [AW-1:0] ra_e;
        while (wq.size() > 0 && wq[0].due <= cyc) begin
            w = wq.pop_front();
            chk("WEN", 32'(bus.WEN), 32'(w.wen));
            chk("REN", 32'(bus.REN), 32'(w.wen));
            chk("LINE_CNT", 32'(bus.LINE_CNT), 32'(w.lc));
            chk("ERR", 32'(bus.ERR), 32'(w.err));
            if (w.wen) begin
                ra_e = '0;
                ra_e[XW-1:0] = w.wa[XW-1:0];
                chk("WA", 32'(bus.WA), 32'(w.wa));
                chk("WD", 32'(bus.WD), 32'(w.wd));
                chk("RA", 32'(bus.RA), 32'(ra_e));
            end
        end
        while (sq.size() > 0 && sq[0].due <= cyc) begin
            s = sq.pop_front();
            chk("VS_OUT", 32'(bus.VS_OUT), 32'(s.vs));
            chk("HS_OUT", 32'(bus.HS_OUT), 32'(s.hs));
            chk("DE_OUT", 32'(bus.DE_OUT), 32'(s.de));
            chk("WIN_VALID", 32'(bus.WIN_VALID), 32'(s.win));
        end
    endtask

    task automatic push_s(input int due, input logic vs, input logic hs, input logic de,
                          input logic win);
        sexp_t s;
        s.due = due; s.vs = vs; s.hs = hs; s.de = de; s.win = win;
        sq.push_back(s);
    endtask

    // One clock of stimulus together with what it must produce.
    task automatic step(input logic vs, input logic hs, input logic de, input logic wen,
                        input logic [AW-1:0] wa, input logic [YW-1:0] lc, input logic win,
                        input logic err);
        wexp_t w;
        logic [DW-1:0] d;
        @(negedge CLK);
        cyc++;
        check_due();
        d = DW'($urandom);
        bus.VS_IN = vs;
        bus.HS_IN = hs;
        bus.DE_IN = de;
        bus.D_IN  = d;
        w.due = cyc + 1; w.wen = wen; w.wa = wa; w.wd = d; w.lc = lc; w.err = err;
        wq.push_back(w);
        push_s(cyc + 3, vs, hs, de, win);
    endtask

    task automatic vs_pulse();
        err_exp = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        end
    endtask

    // A line of npix DE cycles as line yv; en=0 means the block should ignore it.
    task automatic send_line(input int yv, input int npix, input logic win, input logic en,
                             input logic gap);
        logic [AW-1:0] wa;
        logic [YW-1:0] lc;
        logic          wen;
        lc = YW'(yv);
        for (int i = 0; i < npix; i++) begin
            wen = en;
            if (ERRCHK && (i >= H_ACT)) begin
                wen = 1'b0;
                if (en) begin
                    err_exp = 1'b1;
                end
            end
            wa = {YW'(yv), XW'(i)};
            step(1'b0, 1'b0, 1'b1, wen, wa, lc, win, err_exp);
        end
        if (gap) begin
            if (en) begin
                lc = YW'(yv + 1);
            end
            step(1'b0, 1'b0, 1'b0, 1'b0, '0, lc, 1'b0, err_exp);
            for (int k = 0; k < 4; k++) begin
                step(1'b0, 1'b1, 1'b0, 1'b0, '0, lc, 1'b0, err_exp);
            end
            for (int k = 0; k < 3; k++) begin
                step(1'b0, 1'b0, 1'b0, 1'b0, '0, lc, 1'b0, err_exp);
            end
        end
    endtask

    // One-cycle RESET with the stream in the given DE state; all outputs must clear.
    task automatic do_reset(input logic de);
        wexp_t w;
        @(negedge CLK);
        cyc++;
        check_due();
        RESET     = 1'b1;
        bus.VS_IN = 1'b0;
        bus.HS_IN = 1'b1;
        bus.DE_IN = de;
        bus.D_IN  = DW'($urandom);
        wq.delete();
        sq.delete();
        @(negedge CLK);
        cyc++;
        chk("rst_WA", 32'(bus.WA), 32'd0);
        chk("rst_WD", 32'(bus.WD), 32'd0);
        chk("rst_RA", 32'(bus.RA), 32'd0);
        chk("rst_WEN", 32'(bus.WEN), 32'd0);
        chk("rst_REN", 32'(bus.REN), 32'd0);
        chk("rst_VS_OUT", 32'(bus.VS_OUT), 32'd0);
        chk("rst_HS_OUT", 32'(bus.HS_OUT), 32'd0);
        chk("rst_DE_OUT", 32'(bus.DE_OUT), 32'd0);
        chk("rst_WIN_VALID", 32'(bus.WIN_VALID), 32'd0);
        chk("rst_LINE_CNT", 32'(bus.LINE_CNT), 32'd0);
        chk("rst_ERR", 32'(bus.ERR), 32'd0);
        RESET     = 1'b0;
        bus.HS_IN = 1'b0;
        bus.DE_IN = 1'b0;
        err_exp   = 1'b0;
        w.due = cyc + 1; w.wen = 1'b0; w.wa = '0; w.wd = '0; w.lc = '0; w.err = 1'b0;
        wq.push_back(w);
        for (int k = 1; k <= 3; k++) begin
            push_s(cyc + k, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        cyc     = 0;
        err_exp = 1'b0;
        RESET   = 1'b1;
        bus.VS_IN = 1'b0;
        bus.HS_IN = 1'b0;
        bus.DE_IN = 1'b0;
        bus.D_IN  = '0;

        //           vs    hs    de    wen   wa          lc      win
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 21'h000000, 10'd0, 1'b0}; // IDLE ignores DE
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 21'h000000, 10'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 21'h000000, 10'd0, 1'b0}; // DE fall in IDLE
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 21'h000000, 10'd0, 1'b0}; // VS+DE rise together
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 21'h000001, 10'd0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 21'h000002, 10'd0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 21'h000000, 10'd1, 1'b0}; // end of line 0
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 21'h000000, 10'd1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 21'h000800, 10'd1, 1'b0}; // line 1 column 0
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 21'h000000, 10'd2, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 21'h000000, 10'd0, 1'b0}; // VS restarts frame
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 21'h000000, 10'd0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 21'h000000, 10'd0, 1'b0};

        do_reset(1'b0);
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].vs, tbl[i].hs, tbl[i].de, tbl[i].wen, tbl[i].wa, tbl[i].lc,
                 tbl[i].win, 1'b0);
        end

        // Full frame start: window becomes valid from line 3
        vs_pulse();
        for (int y = 0; y < 5; y++) begin
            send_line(y, H_ACT, (y >= 3), 1'b1, 1'b1);
        end
        // VS mid-line 5 at column 600: frame restarts, fill again
        send_line(5, 600, 1'b1, 1'b1, 1'b0);
        vs_pulse();
        for (int y = 0; y < 4; y++) begin
            send_line(y, H_ACT, (y >= 3), 1'b1, 1'b1);
        end
        // RESET during line 4, then DE ignored until the next VS
        send_line(4, 100, 1'b1, 1'b1, 1'b0);
        do_reset(1'b1);
        send_line(0, 20, 1'b0, 1'b0, 1'b1);
        send_line(0, 20, 1'b0, 1'b0, 1'b1);
        vs_pulse();
        send_line(0, 16, 1'b0, 1'b1, 1'b1);
        // Over-long line, then VS clears any error
        vs_pulse();
        send_line(0, H_ACT + 10, 1'b0, 1'b1, 1'b1);
        vs_pulse();
        send_line(0, 8, 1'b0, 1'b1, 1'b1);

        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            cyc++;
            check_due();
        end
        if (wq.size() != 0 || sq.size() != 0) begin
            chk("queue_drain", 32'(wq.size() + sq.size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
